muldiv_sequencer: RTL and testbench

Multi-cycle controller plus iterative datapath for the M-extension operations flagged by the ALU control's `valid`/`mode` outputs.
- Accepts one MUL or DIV request and runs 32 shift-add or restoring-divide iterations.
- Holds the pipeline stalled while busy.
- Presents the 2×XLEN result for exactly one cycle.
- Sits beside the main ALU in EX; the ALU result mux selects `out_lo` when `done` is high.

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/muldiv_sequencer_if.sv | 13 +
 rtl/muldiv_step.sv | 24 ++
 rtl/muldiv_sequencer.sv | 64 ++++++
 tb/tb_muldiv_sequencer.sv | 109 ++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, mode codes and default width for the mul/div sequencer.
package muldiv_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_OUT} state_t;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between ALU control and the mul/div sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = muldiv_pkg::XLEN_DEF);
  logic valid;
  logic mode;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic stall;
  logic done;
  logic [XLEN-1:0] out_lo;
  logic [XLEN-1:0] out_hi;
  modport master (output valid, mode, in_a, in_b, input stall, done, out_lo, out_hi);
  modport slave (input valid, mode, in_a, in_b, output stall, done, out_lo, out_hi);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on the {hi,lo} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0] sum, r_sh, trial;
  logic fits;
  assign {hi, lo} = acc_i;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, b_i} : '0);
  assign r_sh = {hi, lo[XLEN-1]};
  // r_sh < 2*B, so the top bit of the difference is exactly the borrow
  assign trial = r_sh - {1'b0, b_i};
  assign fits = ~trial[XLEN];
  assign acc_o = (mode_i == MODE_DIV)
               ? {fits ? trial[XLEN-1:0] : r_sh[XLEN-1:0], lo[XLEN-2:0], fits}
               : {sum, lo[XLEN-1:1]};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-iteration unsigned MUL/DIV controller that stalls EX and pulses done with the result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input logic clk,
  input logic rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] b_q, out_lo_q, out_hi_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic last;
  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_i(state_q == S_DIV),
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (acc_d)
  );
  assign last = cnt_q == CNT_W'(XLEN - 1);
  assign bus.stall = rst_n & ((state_q == S_IDLE & bus.valid) | state_q == S_MUL | state_q == S_DIV);
  assign bus.done = state_q == S_OUT;
  assign bus.out_lo = out_lo_q;
  assign bus.out_hi = out_hi_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      out_lo_q <= '0;
      out_hi_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.valid) begin
          b_q <= bus.in_b;
          cnt_q <= '0;
          acc_q <= {{XLEN{1'b0}}, bus.in_a};
          // divide by zero skips iteration: quotient all ones, remainder = dividend
          if (bus.mode == MODE_MUL) state_q <= S_MUL;
          else if (bus.in_b != '0) state_q <= S_DIV;
          else begin
            state_q <= S_OUT;
            out_lo_q <= '1;
            out_hi_q <= bus.in_a;
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= S_OUT;
            out_lo_q <= acc_d[XLEN-1:0];
            out_hi_q <= acc_d[2*XLEN-1:XLEN];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with a result scoreboard checked by an independent done monitor.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] sb[$];
  muldiv_sequencer_if #(.XLEN(32)) bus ();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (bus.done) begin
      if (sb.size() == 0) chk("unexpected done", {bus.out_hi, bus.out_lo}, 64'hx);
      else chk("result {hi,lo}", {bus.out_hi, bus.out_lo}, sb.pop_front());
    end
  end
  task automatic run_op(input string nm, input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi, input int lat, input bit poke);
    bit seen = 0;
    bus.valid = 1'b1;
    bus.mode = m;
    bus.in_a = a;
    bus.in_b = b;
    @(negedge clk);
    chk({nm, " stall cycle0"}, 64'(bus.stall), 64'd1);
    sb.push_back({hi, lo});
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.mode = ~m;
    bus.in_a = ~a;
    bus.in_b = b + 32'd3;
    for (int cyc = 1; cyc < 64 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " stall at done"}, 64'(bus.stall), 64'd0);
      end else if (bus.stall !== 1'b1) chk({nm, " stall busy"}, 64'(bus.stall), 64'd1);
      if (poke) begin
        bus.valid = cyc >= 4 && cyc <= 8;
        bus.in_a = 32'h55 + 32'(cyc);
        bus.in_b = 32'h99;
      end
    end
    if (!seen) chk({nm, " timeout"}, 64'd0, 64'd1);
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.valid = 1'b0;
    bus.mode = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    #2;
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset out", {bus.out_hi, bus.out_lo}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("mul 7x6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 33, 0);
    run_op("mul ffx ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, 0);
    run_op("mul shift", 1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, 33, 0);
    run_op("mul zero", 1'b0, 32'd0, 32'h123, 32'd0, 32'd0, 33, 0);
    run_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
    run_op("div 5/9", 1'b1, 32'd5, 32'd9, 32'd0, 32'd5, 33, 0);
    run_op("div 5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
    run_op("div max/1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("mul poked", 1'b0, 32'd3, 32'd5, 32'd15, 32'd0, 33, 1);
    repeat (40) @(posedge clk);
    #1;
    bus.valid = 1'b1;
    bus.mode = 1'b1;
    bus.in_a = 32'd100;
    bus.in_b = 32'd7;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre-reset stall", 64'(bus.stall), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset stall", 64'(bus.stall), 64'd0);
    chk("async reset done", 64'(bus.done), 64'd0);
    chk("async reset out", {bus.out_hi, bus.out_lo}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("idle after abort", 64'(bus.stall), 64'd0);
    run_op("div 1000/10", 1'b1, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 0);
    repeat (5) @(posedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
